// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default sizes for the round-robin memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 2;
    localparam int N_REQ  = 2;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// rtl/mem_rr_arbiter_if.sv - requester, response and memory-side signals of the arbiter
interface mem_rr_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ-1:0][AW-1:0] req_addr;
    logic [N_REQ-1:0][DW-1:0] req_wdata;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_valid;
    logic [DW-1:0]            rsp_rdata;
    logic                     mem_wr_en;
    logic                     mem_rd_en;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_wdata;
    logic [DW-1:0]            mem_rdata;

    // Arbiter side
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rsp_valid, rsp_rdata, mem_wr_en, mem_rd_en, mem_addr, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rsp_valid, rsp_rdata, mem_wr_en, mem_rd_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick2.sv
// rtl/mem_rr_arbiter_rr_pick2.sv - two-way round-robin winner selection
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       winner_o,
    output logic       any_o
);

    // A lone requester always wins; on contention the one not served last wins
    always_comb begin
        winner_o = 1'b0;
        any_o    = |req_i;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_owner_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-requester round-robin sequencer in front of a single-port memory
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_rr_arbiter_if.slave  bus
);

    state_t          state_q, state_d;
    logic            last_owner_q, last_owner_d;
    logic            owner_q, owner_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            mem_wr_en_q, mem_wr_en_d;
    logic            mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic            winner;
    logic            any_req;

    rr_pick2 u_pick (
        .req_i        (bus.req),
        .last_owner_i (last_owner_q),
        .winner_o     (winner),
        .any_o        (any_req)
    );

    // Next state and next registered outputs; pulses default low every cycle
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        gnt_d        = 2'b00;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = rsp_rdata_q;
        mem_wr_en_d  = 1'b0;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d[winner] = 1'b1;
                    mem_addr_d    = bus.req_addr[winner];
                    owner_d       = winner;
                    last_owner_d  = winner;
                    if (bus.req_we[winner]) begin
                        mem_wr_en_d = 1'b1;
                        mem_wdata_d = bus.req_wdata[winner];
                        state_d     = WR;
                    end else begin
                        mem_rd_en_d = 1'b1;
                        state_d     = RD;
                    end
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_rdata_d          = bus.mem_rdata;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; last_owner resets to 1 so requester 0 wins first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - scoreboard bench for the round-robin memory arbiter
module tb_mem_rr_arbiter;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
    } op_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    op_t  q0[$];
    op_t  q1[$];
    exp_t exp_q[$];
    int   grant_log[$];
    logic [7:0] rsp_log[$];

    logic [7:0] mem [4]       = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] model_mem [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] mem_rdata_r;
    int         last_g  = 1;
    int         free_at = 0;

    mem_rr_arbiter_if #(.DW(8), .AW(2)) bus ();

    mem_rr_arbiter #(.DW(8), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: 4x8, registered read data, power-up contents 8'hFF
    assign bus.mem_rdata = mem_rdata_r;
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) mem_rdata_r <= mem[bus.mem_addr];
    end

    function automatic op_t mk(input bit we, input int a, input int d);
        op_t o;
        o.we = we; o.addr = a[1:0]; o.data = d[7:0];
        return o;
    endfunction

    function automatic bit outs_zero();
        return bus.gnt == 2'b00 && bus.rsp_valid == 2'b00 && bus.rsp_rdata == 8'h00 &&
               !bus.mem_wr_en && !bus.mem_rd_en && bus.mem_addr == 2'b00 && bus.mem_wdata == 8'h00;
    endfunction

    // Driver and transaction-level model: predicts each grant, applies it to the model memory
    initial begin
        logic [1:0] sampled, exp_gnt;
        int         w;
        op_t        op;
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                last_g  = 1;
                free_at = cyc + 2;
            end else begin
                sampled = bus.req;
                exp_gnt = 2'b00;
                if (cyc >= free_at && sampled != 2'b00) begin
                    if (sampled == 2'b11) w = (last_g == 1) ? 0 : 1;
                    else w = sampled[1] ? 1 : 0;
                    exp_gnt = (w == 1) ? 2'b10 : 2'b01;
                end
                if (exp_gnt != 2'b00 || bus.gnt != 2'b00) begin
                    vectors++;
                    if (bus.gnt !== exp_gnt) begin
                        miscompares++;
                        $display("FAIL gnt cycle %0d: got %b expected %b", cyc, bus.gnt, exp_gnt);
                    end
                end
                if (bus.gnt == 2'b01 || bus.gnt == 2'b10) begin
                    w = bus.gnt[1] ? 1 : 0;
                    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                        vectors++; miscompares++;
                        $display("FAIL spurious_gnt cycle %0d: got %b expected none", cyc, bus.gnt);
                    end else begin
                        op = (w == 0) ? q0.pop_front() : q1.pop_front();
                        vectors++;
                        if (bus.mem_addr !== op.addr || bus.mem_wr_en !== op.we ||
                            bus.mem_rd_en !== !op.we || (op.we && bus.mem_wdata !== op.data)) begin
                            miscompares++;
                            $display("FAIL mem_cmd cycle %0d: got wr=%b rd=%b a=%0d d=%h expected we=%b a=%0d d=%h",
                                     cyc, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata,
                                     op.we, op.addr, op.data);
                        end
                        if (op.we) begin
                            model_mem[op.addr] = op.data;
                            free_at = cyc + 2;
                        end else begin
                            exp_q.push_back('{owner: w, data: model_mem[op.addr], due: cyc + 2});
                            free_at = cyc + 3;
                        end
                        grant_log.push_back(w);
                        last_g = w;
                    end
                end
            end
            bus.req[0] = (q0.size() > 0);
            if (q0.size() > 0) begin
                bus.req_we[0] = q0[0].we; bus.req_addr[0] = q0[0].addr; bus.req_wdata[0] = q0[0].data;
            end
            bus.req[1] = (q1.size() > 0);
            if (q1.size() > 0) begin
                bus.req_we[1] = q1[0].we; bus.req_addr[1] = q1[0].addr; bus.req_wdata[1] = q1[0].data;
            end
        end
    end

    // Monitor: reset outputs, exclusivity invariants, response scoreboard
    initial begin
        exp_t       e;
        logic [1:0] ev;
        forever begin
            @(negedge clk);
            if (rst) begin
                vectors++;
                if (!outs_zero()) begin
                    miscompares++;
                    $display("FAIL reset_outs cycle %0d: got gnt=%b rsp=%b wr=%b rd=%b expected all 0",
                             cyc, bus.gnt, bus.rsp_valid, bus.mem_wr_en, bus.mem_rd_en);
                end
            end else begin
                if ((bus.mem_wr_en && bus.mem_rd_en) || bus.gnt == 2'b11 || bus.rsp_valid == 2'b11 ||
                    ((bus.mem_wr_en || bus.mem_rd_en) != (bus.gnt != 2'b00))) begin
                    vectors++; miscompares++;
                    $display("FAIL exclusive cycle %0d: got gnt=%b wr=%b rd=%b rsp=%b expected one op",
                             cyc, bus.gnt, bus.mem_wr_en, bus.mem_rd_en, bus.rsp_valid);
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e  = exp_q.pop_front();
                    ev = (e.owner == 1) ? 2'b10 : 2'b01;
                    vectors++;
                    if (bus.rsp_valid !== ev || bus.rsp_rdata !== e.data) begin
                        miscompares++;
                        $display("FAIL rsp cycle %0d: got valid=%b data=%h expected valid=%b data=%h",
                                 cyc, bus.rsp_valid, bus.rsp_rdata, ev, e.data);
                    end
                    rsp_log.push_back(bus.rsp_rdata);
                end else if (bus.rsp_valid != 2'b00) begin
                    vectors++; miscompares++;
                    $display("FAIL rsp_unexpected cycle %0d: got valid=%b expected 00", cyc, bus.rsp_valid);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < 500) begin
            step(); n++;
        end
        step(); step();
        vectors++;
        if (n >= 500) begin
            miscompares++;
            $display("FAIL drain_%s: got %0d pending ops expected 0", name, q0.size() + q1.size() + exp_q.size());
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_grants(input string name, input int n, input int w0, input int w1, input int w2, input int w3);
        int want[4];
        want = '{w0, w1, w2, w3};
        check_int({name, "_count"}, grant_log.size(), n);
        for (int i = 0; i < n && i < grant_log.size(); i++)
            check_int($sformatf("%s_order%0d", name, i), grant_log[i], want[i]);
    endtask

    task automatic check_rsp(input string name, input int idx, input logic [7:0] want);
        vectors++;
        if (idx >= rsp_log.size() || rsp_log[idx] !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, (idx < rsp_log.size()) ? rsp_log[idx] : 8'hxx, want);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Read of reset memory contents
        grant_log.delete(); rsp_log.delete();
        q0.push_back(mk(0, 2, 0));
        drain("t1");
        check_grants("t1_gnt", 1, 0, 0, 0, 0);
        check_rsp("t1_rdata", 0, 8'hFF);

        // Requester 1 write then read back
        grant_log.delete(); rsp_log.delete();
        q1.push_back(mk(1, 1, 8'hA5));
        q1.push_back(mk(0, 1, 0));
        drain("t2");
        check_grants("t2_gnt", 2, 1, 1, 0, 0);
        check_rsp("t2_rdata", 0, 8'hA5);

        // Continuous contention alternates grants
        grant_log.delete(); rsp_log.delete();
        q0.push_back(mk(1, 0, 8'hAA)); q0.push_back(mk(0, 0, 0));
        q1.push_back(mk(1, 3, 8'h55)); q1.push_back(mk(0, 3, 0));
        drain("t3");
        check_grants("t3_gnt", 4, 0, 1, 0, 1);
        check_rsp("t3_rdata0", 0, 8'hAA);
        check_rsp("t3_rdata1", 1, 8'h55);

        // Simultaneous read and write to the same word
        grant_log.delete(); rsp_log.delete();
        q0.push_back(mk(0, 0, 0));
        q1.push_back(mk(1, 0, 8'h3C));
        drain("t4a");
        q0.push_back(mk(0, 0, 0));
        drain("t4b");
        check_grants("t4_gnt", 3, 0, 1, 0, 0);
        check_rsp("t4_old", 0, 8'hAA);
        check_rsp("t4_new", 1, 8'h3C);

        // Reset during the read grant cycle
        grant_log.delete(); rsp_log.delete();
        q0.push_back(mk(0, 2, 0));
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.gnt[0] && n < 20);
        check_int("t5_gnt_seen", bus.gnt[0], 1);
        #2 rst = 1'b1;
        #1 check_int("t5_outs_cleared", outs_zero(), 1);
        q0.delete(); q1.delete();
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        check_int("t5_no_rsp", rsp_log.size(), 0);
        grant_log.delete();
        q1.push_back(mk(0, 1, 0));
        drain("t5");
        check_grants("t5_gnt", 1, 1, 0, 0, 0);
        check_rsp("t5_rdata", 0, 8'hA5);

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            step();
            check_int($sformatf("idle%0d", i),
                      (bus.gnt != 0) || bus.mem_wr_en || bus.mem_rd_en || (bus.rsp_valid != 0), 0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0 && q0.size() < 3)
                q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255)));
            if ($urandom_range(0, 2) != 0 && q1.size() < 3)
                q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255)));
            step();
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 4x8 single-port memory.
- Accepts one read or write per grant from either requester.
- Drives the memory's wr_en/rd_en/addr/wdata one operation at a time, captures the registered memory read data, and returns it to the requester that issued the read.
- Sits between testbench or agent requesters and the memory interface signals.

Parameters:
- DW, 8, data width (matches memory word width)
- AW, 2, address width (4 words)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-requester request; held until gnt seen
- req_we  in  2  per-requester op: 1=write, 0=read
- req_addr  in  2xAW  per-requester address
- req_wdata  in  2xDW  per-requester write data
- gnt  out  2  one-cycle grant pulse (one-hot or zero)
- rsp_valid  out  2  one-cycle read-data-valid pulse to the read owner
- rsp_rdata  out  DW  read data; valid while rsp_valid != 0
- mem_wr_en  out  1  to memory write enable
- mem_rd_en  out  1  to memory read enable
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory registered read data

Behaviour:
- Reset values, async on rst high: all outputs 0; state=IDLE; last_owner=1 so requester 0 wins first contention; owner=0.
- All outputs are registered.
- FSM states: IDLE, WR, RD, RD_WAIT.
- IDLE:
  - no req: stay IDLE, mem enables 0.
  - any req: pick winner w. Only one requesting wins. Both requesting wins !last_owner.
  - At the edge, register gnt[w]=1, mem_addr=req_addr[w], owner=w, last_owner=w.
  - If req_we[w]: mem_wr_en=1, mem_wdata=req_wdata[w], go WR. Else mem_rd_en=1, go RD.
- WR, one cycle: gnt, mem_wr_en → 0; go IDLE. The memory samples the write at this edge.
- RD, one cycle: gnt, mem_rd_en → 0; go RD_WAIT. The memory samples the read at this edge; mem_rdata is valid in the RD_WAIT cycle.
- RD_WAIT: at the edge, rsp_rdata=mem_rdata, rsp_valid[owner]=1 for one cycle; go IDLE.
- mem_addr and mem_wdata hold their last values between ops; they are only meaningful while an enable is high.
- Latency, counted from the edge where IDLE samples req:
  - gnt high the next cycle (C1).
  - Write committed at the end of C1.
  - Read rsp_valid in C3.
- Throughput: write 1 per 2 cycles; read 1 per 3 cycles.
- Handshake:
  - Requester must hold req, req_we, req_addr and req_wdata stable until it sees gnt, then drop req or present its next op.
  - req is not sampled outside IDLE, so no double issue.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- Never more than one mem enable high; never both gnt bits high; rsp_valid never pulses for writes.
- Mid-operation reset: the in-flight op is abandoned, outputs clear immediately, and no rsp_valid follows. A write whose mem_wr_en was already sampled is not undone.
- Address wraps naturally within AW bits; no out-of-range checking.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, WR, RD, RD_WAIT}
  - localparams DW_DEF=8, AW_DEF=2, N_REQ=2
- Sub-module rr_pick2, combinational:
  - inputs req[1:0], last_owner; outputs winner and any.
  - Holds the round-robin rule for reuse by future wider arbiters.
- Top holds the FSM, the registered outputs and the response capture.

Test Plan:
- After reset, req0 read addr 2 → gnt=01 in C1, mem_rd_en=1 with mem_addr=2, rsp_valid=01 in C3, rsp_rdata=8'hFF (memory reset value).
- req1 write addr 1 data 8'hA5, then req1 read addr 1 → gnt=10 twice, mem_wr_en one cycle with mem_wdata=A5, read returns rsp_valid=10 and rsp_rdata=A5.
- req0 and req1 both held with writes (addr0=AA, addr3=55) → gnt order 01,10,01,10 across 4 grants, first grant to 0; reads of addr 0 and 3 return AA and 55.
- req0 read addr 0 while req1 write addr 0 data 8'h3C in the same cycle → req0 granted first, its read returns the old value; write follows; a later read returns 3C.
- rst asserted in the RD cycle → all outputs 0 immediately, no rsp_valid afterwards; after release, the next req1-only request is granted normally.
- Idle bus, req=00 for 10 cycles → gnt, mem_wr_en, mem_rd_en and rsp_valid stay 0 throughout.
